// File: rtl/u_ramp.sv
// ---------------------------------------------------------------------------
// u_ramp -- thermometer-code ramp generator
//
// Holds a level (0..W-1) and presents it as a registered thermometer code.
// A new target is accepted only while idle. The level then walks one step
// per unstalled clock until it reaches the target. The first step is taken
// on the accepting edge itself.
//
// Parameters
//   W                 code width (>= 2)
//   LW                level field width, $clog2(W)+1, so out-of-range
//                     targets can still be expressed on i_tgt_lvl
//
// Ports
//   clk               rising-edge clock
//   arst_n            asynchronous active-low reset
//   i_tgt_vld         target request valid
//   i_tgt_lvl         requested level (legal 0..W-1)
//   i_tgt_cmp         request the inverted output form (sampled on accept)
//   o_tgt_rdy         block is idle and can accept a target
//   i_stall           freeze ramp progress (no effect while idle)
//   o_code            registered thermometer code of the current level
//   o_is_compliment   o_code is presented inverted
//   o_busy            ramp in progress
//   o_done            one-cycle pulse: target level reached
//   o_err             one-cycle pulse: target rejected as out of range
//
// Configuration
//   U_RAMP_ADMIT_COMPLIMENT_EN  defined: i_tgt_cmp selects the inverted form.
//                               undefined: i_tgt_cmp is ignored and o_code
//                               is always in true form.
// ---------------------------------------------------------------------------
module u_ramp #(
    parameter  int W  = 16,
    localparam int LW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_tgt_vld,
    input  logic [LW-1:0] i_tgt_lvl,
    input  logic          i_tgt_cmp,
    output logic          o_tgt_rdy,
    input  logic          i_stall,
    output logic [W-1:0]  o_code,
    output logic          o_is_compliment,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] cur;
    logic [LW-1:0] tgt;
    logic          cmp;

    logic          cmp_in;
    logic          lvl_ok;
    logic          mv_up;
    logic          arrive;
    logic          form_cmp;
    logic [LW-1:0] mv_tgt;
    logic [LW-1:0] stepped;
    logic [W-1:0]  code_hold;
    logic [W-1:0]  code_step;

    // Thermometer code of level k: bits [k-1:0] set, the rest clear.
    function automatic logic [W-1:0] therm(input logic [LW-1:0] k);
        logic [W-1:0] t;
        for (int i = 0; i < W; i++) begin
            t[i] = (LW'(i) < k);
        end
        return t;
    endfunction

`ifdef U_RAMP_ADMIT_COMPLIMENT_EN
    assign cmp_in          = i_tgt_cmp;
    assign o_is_compliment = cmp;
`else
    // The port stays for interface compatibility; the request is dropped.
    logic unused_tgt_cmp;
    assign unused_tgt_cmp  = i_tgt_cmp;
    assign cmp_in          = 1'b0;
    assign o_is_compliment = 1'b0;
`endif

    assign lvl_ok = (i_tgt_lvl <= LW'(W - 1));

    // Step computation shared by the accepting edge (idle, toward the new
    // target) and the ramp edges (toward the latched target).
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        mv_tgt   = tgt;
        mv_up    = (state == UP);
        form_cmp = cmp;
        if (state == IDLE) begin
            mv_tgt   = i_tgt_lvl;
            mv_up    = (i_tgt_lvl > cur);
            form_cmp = cmp_in;
        end
        stepped   = mv_up ? cur + LW'(1) : cur - LW'(1);
        arrive    = (stepped == mv_tgt);
        code_hold = therm(cur)     ^ {W{form_cmp}};
        code_step = therm(stepped) ^ {W{form_cmp}};
    end

    // NOTE: state and every output are flops updated with non-blocking
    // assignments, so all of them change together on the same edge and
    // o_code never shows a combinational glitch.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cur       <= '0;
            tgt       <= '0;
            cmp       <= 1'b0;
            o_code    <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_tgt_rdy <= 1'b1;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tgt_vld) begin
                        if (!lvl_ok) begin
                            // Rejected: level, form and state are untouched.
                            o_err <= 1'b1;
                        end else begin
                            tgt <= i_tgt_lvl;
                            cmp <= cmp_in;
                            if (i_tgt_lvl == cur) begin
                                // Already there; only the form may change.
                                o_code <= code_hold;
                                o_done <= 1'b1;
                            end else begin
                                cur    <= stepped;
                                o_code <= code_step;
                                if (arrive) begin
                                    // One step away: finished on this edge.
                                    o_done <= 1'b1;
                                end else begin
                                    state     <= mv_up ? UP : DOWN;
                                    o_busy    <= 1'b1;
                                    o_tgt_rdy <= 1'b0;
                                end
                            end
                        end
                    end
                end
                UP, DOWN: begin
                    if (!i_stall) begin
                        cur    <= stepped;
                        o_code <= code_step;
                        if (arrive) begin
                            state     <= IDLE;
                            o_busy    <= 1'b0;
                            o_tgt_rdy <= 1'b1;
                            o_done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_busy    <= 1'b0;
                    o_tgt_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u_ramp.sv
// ---------------------------------------------------------------------------
// tb_u_ramp -- self-checking bench for u_ramp at W=8
//
// Each scenario task drives one request/idle cycle at a time and pushes the
// outputs it expects after the following rising edge onto a scoreboard
// queue. A monitor pops and compares one entry per edge, and on every cycle
// also checks that the un-inverted code is a legal thermometer code and that
// o_done and o_err never coincide. Reset behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_u_ramp;

    localparam int W  = 8;
    localparam int LW = $clog2(W) + 1;

`ifdef U_RAMP_ADMIT_COMPLIMENT_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] code;
        logic         cmp;
        logic         busy;
        logic         done;
        logic         err;
        logic         rdy;
    } obs_t;

    logic          clk       = 1'b0;
    logic          arst_n    = 1'b1;
    logic          i_tgt_vld = 1'b0;
    logic [LW-1:0] i_tgt_lvl = '0;
    logic          i_tgt_cmp = 1'b0;
    logic          i_stall   = 1'b0;
    logic          o_tgt_rdy;
    logic [W-1:0]  o_code;
    logic          o_is_compliment;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    obs_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    string tag      = "reset";

    u_ramp #(.W(W)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .i_tgt_vld       (i_tgt_vld),
        .i_tgt_lvl       (i_tgt_lvl),
        .i_tgt_cmp       (i_tgt_cmp),
        .o_tgt_rdy       (o_tgt_rdy),
        .i_stall         (i_stall),
        .o_code          (o_code),
        .o_is_compliment (o_is_compliment),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    // Expected thermometer value of level k, written arithmetically.
    function automatic logic [W-1:0] therm_of(input int k);
        int v;
        v = (1 << k) - 1;
        return v[W-1:0];
    endfunction

    function automatic obs_t mk(input int k, input bit c, input bit busy,
                                input bit done, input bit err);
        obs_t o;
        o.code = c ? ~therm_of(k) : therm_of(k);
        o.cmp  = c;
        o.busy = busy;
        o.done = done;
        o.err  = err;
        o.rdy  = ~busy;
        return o;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the outputs
    // expected after the next rising edge.
    task automatic cyc(input bit vld, input int lvl, input bit cmp,
                       input bit stall, input obs_t e);
        @(negedge clk);
        i_tgt_vld = vld;
        i_tgt_lvl = LW'(lvl);
        i_tgt_cmp = cmp;
        i_stall   = stall;
        exp_q.push_back(e);
    endtask

    // Scoreboard and per-cycle invariants, sampled 1 time unit after each edge.
    always @(posedge clk) begin : monitor
        obs_t         e;
        obs_t         a;
        logic [W-1:0] x;
        #1;
        if (arst_n) begin
            x = o_is_compliment ? ~o_code : o_code;
            checks++;
            if ((((x + 1'b1) & x)) !== '0) begin
                failures++;
                $display("FAIL unary[%s] t=%0t: code=%h is_compliment=%b not a thermometer code",
                         tag, $time, o_code, o_is_compliment);
            end
            checks++;
            if ((o_done & o_err) !== 1'b0) begin
                failures++;
                $display("FAIL done_err_excl[%s] t=%0t: done=%b err=%b, required not both",
                         tag, $time, o_done, o_err);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{code: o_code, cmp: o_is_compliment, busy: o_busy,
                  done: o_done, err: o_err, rdy: o_tgt_rdy};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL sb[%s] t=%0t: got code=%h cmp=%b busy=%b done=%b err=%b rdy=%b, want code=%h cmp=%b busy=%b done=%b err=%b rdy=%b",
                         tag, $time, a.code, a.cmp, a.busy, a.done, a.err, a.rdy,
                         e.code, e.cmp, e.busy, e.done, e.err, e.rdy);
            end
        end
    end

    task automatic test_reset();
        obs_t a;
        tag = "reset";
        #1 arst_n = 1'b0;
        #1;
        a = '{code: o_code, cmp: o_is_compliment, busy: o_busy,
              done: o_done, err: o_err, rdy: o_tgt_rdy};
        checks++;
        if (a !== mk(0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_state: got code=%h cmp=%b busy=%b done=%b err=%b rdy=%b, want all clear with rdy=1",
                     a.code, a.cmp, a.busy, a.done, a.err, a.rdy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // 0 -> 5; a request arriving while busy must be ignored.
    task automatic test_ramp_up();
        tag = "ramp_up";
        cyc(1'b1, 5, 1'b0, 1'b0, mk(1, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b1, 9, 1'b0, 1'b0, mk(2, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b1, 1, 1'b0, 1'b0, mk(3, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(4, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(5, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(5, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // 5 -> 2
    task automatic test_ramp_down();
        tag = "ramp_down";
        cyc(1'b1, 2, 1'b0, 1'b0, mk(4, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(3, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Rejected targets at level 2: 9, W (first illegal) and the field maximum.
    task automatic test_out_of_range();
        tag = "out_of_range";
        cyc(1'b1, 9,        1'b1, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 0,        1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(1'b1, W,        1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b1, 2**LW - 1, 1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 0,        1'b0, 1'b0, mk(2, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Target equal to the current level: immediate done, form updated.
    task automatic test_same_level();
        tag = "same_level";
        cyc(1'b1, 2, 1'b1, 1'b0, mk(2, CMP_EN, 1'b0, 1'b1, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(2, CMP_EN, 1'b0, 1'b0, 1'b0));
        cyc(1'b1, 2, 1'b0, 1'b0, mk(2, 1'b0,   1'b0, 1'b1, 1'b0));
        // Stall while idle has no effect.
        cyc(1'b0, 0, 1'b0, 1'b1, mk(2, 1'b0,   1'b0, 0, 1'b0));
    endtask

    // 2 -> 0, then 0 -> 7 with a 3-cycle stall; done 10 cycles after accept.
    task automatic test_stall();
        tag = "stall";
        cyc(1'b1, 0, 1'b0, 1'b0, mk(1, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b1, 7, 1'b0, 1'b0, mk(1, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(2, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(3, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 0, 1'b0, 1'b1, mk(3, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        cyc(1'b0, 0, 1'b0, 1'b0, mk(4, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(5, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(6, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(7, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b1, W, 1'b0, 1'b0, mk(7, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(7, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // 7 -> 0, then 0 -> 3 requesting the inverted form, then back to true form.
    task automatic test_complement();
        tag = "complement";
        cyc(1'b1, 0, 1'b0, 1'b0, mk(6, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 5; k > 0; k--) begin
            cyc(1'b0, 0, 1'b0, 1'b0, mk(k, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        cyc(1'b0, 0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(1'b1, 3, 1'b1, 1'b0, mk(1, CMP_EN, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(2, CMP_EN, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(3, CMP_EN, 1'b0, 1'b1, 1'b0));
        cyc(1'b1, 3, 1'b0, 1'b0, mk(3, 1'b0,   1'b0, 1'b1, 1'b0));
        cyc(1'b0, 0, 1'b0, 1'b0, mk(3, 1'b0,   1'b0, 1'b0, 1'b0));
    endtask

    // 3 -> 7 interrupted by reset at level 4: code clears at once, no done.
    task automatic test_reset_mid_ramp();
        obs_t a;
        tag = "reset_mid_ramp";
        cyc(1'b1, 7, 1'b0, 1'b0, mk(4, 1'b0, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        i_tgt_vld = 1'b0;
        arst_n    = 1'b0;
        #1;
        a = '{code: o_code, cmp: o_is_compliment, busy: o_busy,
              done: o_done, err: o_err, rdy: o_tgt_rdy};
        checks++;
        if (a !== mk(0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL async_reset: got code=%h cmp=%b busy=%b done=%b err=%b rdy=%b, want all clear with rdy=1",
                     a.code, a.cmp, a.busy, a.done, a.err, a.rdy);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_out_of_range();
        test_same_level();
        test_stall();
        test_complement();
        test_reset_mid_ramp();
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case a scenario ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/u_ramp.md
U_RAMP -- requirements
Module: u_ramp

Interface
REQ-001 Parameter: W, 16, code bit-width; SHALL be >= 2.
REQ-002 Derived: LW = $clog2(W)+1, level field width, wide enough to express out-of-range targets.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_tgt_vld  input  1  target request valid.
REQ-006 i_tgt_lvl  input  LW  requested level, legal range 0..W-1.
REQ-007 i_tgt_cmp  input  1  request complement output form; sampled with the target.
REQ-008 o_tgt_rdy  output  1  block can accept a target.
REQ-009 i_stall  input  1  freeze ramp progress.
REQ-010 o_code  output  W  registered thermometer code for current level k: bits [k-1:0] set, rest clear.
REQ-011 o_is_compliment  output  1  o_code is presented inverted.
REQ-012 o_busy  output  1  ramp in progress.
REQ-013 o_done  output  1  single-cycle pulse: target level reached.
REQ-014 o_err  output  1  single-cycle pulse: target rejected as out of range.

Function
REQ-015 States: IDLE, UP, DOWN; internal level register cur (0..W-1), target register tgt, complement flag cmp.
REQ-016 o_tgt_rdy SHALL be 1 only in IDLE; a request is accepted when i_tgt_vld & o_tgt_rdy at a rising edge.
REQ-017 Accept with i_tgt_lvl > W-1: o_err=1 for the following cycle; state, cur, cmp unchanged.
REQ-018 Accept with i_tgt_lvl == cur: o_done=1 for the following cycle; stay IDLE; cmp updated.
REQ-019 Accept with i_tgt_lvl > cur: go UP; i_tgt_lvl < cur: go DOWN; tgt and cmp latched.
REQ-020 UP/DOWN: each edge with i_stall=0 SHALL change cur by exactly +1/-1; i_stall=1 holds cur and state.
REQ-021 Edge at which the updated cur equals tgt: return to IDLE and assert o_done for that next cycle, coincident with o_code first showing tgt.
REQ-022 Latency: accept to o_done = |tgt - cur| cycles plus stall cycles; o_code changes by one bit per non-stalled cycle.
REQ-023 o_code SHALL be driven directly from flops, always a legal unary code (never more than one transition point), in both forms.
REQ-024 o_is_compliment = cmp; when set, o_code = ~thermometer(cur); cmp changes only on accept.
REQ-025 o_busy = (state != IDLE); i_tgt_vld while busy SHALL be ignored (no accept, no error).
REQ-026 i_stall in IDLE has no effect; accept is not blocked by i_stall.
REQ-027 o_done and o_err SHALL never assert in the same cycle.

Reset
REQ-028 arst_n low SHALL immediately force: state IDLE, cur=0, tgt=0, cmp=0, o_code=all-zero, o_is_compliment=0, o_busy=0, o_done=0, o_err=0, o_tgt_rdy=1 once deasserted.
REQ-029 Reset mid-ramp SHALL abandon the ramp with no o_done pulse.

Configuration
REQ-030 Macro U_RAMP_ADMIT_COMPLIMENT_EN: defined -> i_tgt_cmp honoured per REQ-024.
REQ-031 Undefined -> i_tgt_cmp ignored, cmp held 0, o_is_compliment tied 0, o_code always true form; ports remain present.

Verification (W=8)
REQ-032 Reset; target 5 accepted -> o_code 0x01,0x03,0x07,0x0F,0x1F on successive cycles; o_done with 0x1F; o_busy high 4 cycles then low.
REQ-033 From level 5, target 2 -> o_code 0x0F,0x07,0x03; o_done with 0x03.
REQ-034 Target 9 from IDLE -> o_err one cycle, o_code unchanged, o_done never high.
REQ-035 Ramp 0->7 with i_stall held 3 cycles mid-ramp -> o_code frozen 3 cycles, o_done 10 cycles after accept.
REQ-036 With macro defined, target 3, i_tgt_cmp=1 -> o_code 0xFE,0xFC,0xF8, o_is_compliment=1; without macro same stimulus -> 0x01,0x03,0x07, o_is_compliment=0.
REQ-037 arst_n pulsed at level 4 during ramp to 7 -> o_code 0x00 asynchronously, no o_done; every cycle of all scenarios o_code (un-inverted) satisfies ((x+1)&x)==0.
